// File: rtl/hex_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_key_pkg
// Purpose  : Shared constants and the digit encoder for hex key entry.
// Revision : 1.0 - initial release
// ============================================================================
package hex_key_pkg;

    localparam int NIBBLES = 8;
    localparam int CTRL_W  = 18;
    localparam int ENT_BIT = 17;
    localparam int DEL_BIT = 16;

    // Lowest set bit wins when several switches rise together.
    function automatic logic [3:0] onehot_lsb_enc(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce
// Purpose  : 2-flop synchronizer, shared-counter debounce and rising-edge detect.
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce #(
    parameter int WIDTH     = 18,
    parameter int DB_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] rise
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_filt_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;

    // Any change anywhere in the vector restarts the shared stability count.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_sync2 != r_prev) begin
            w_cnt_next = '0;
        end else if (r_cnt != c_cnt_max) begin
            w_cnt_next = r_cnt + 1'b1;
        end
        w_accept = (w_cnt_next == c_cnt_max);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_cnt    <= '0;
            r_filt   <= '0;
            r_filt_d <= '0;
        end else begin
            r_sync1  <= raw;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_cnt    <= w_cnt_next;
            r_filt_d <= r_filt;
            if (w_accept) r_filt <= r_sync2;
        end
    end

    assign rise = r_filt & ~r_filt_d;

endmodule
`default_nettype wire

// File: rtl/hex_key_entry.sv
`default_nettype none
// ============================================================================
// Module   : hex_key_entry
// Purpose  : Debounced hex keypad entry with backspace and commit.
// Revision : 1.0 - initial release
// ============================================================================
module hex_key_entry
    import hex_key_pkg::*;
#(
    parameter int DB_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] hd,
    input  logic        del,
    input  logic        ent,
    output logic [31:0] din,
    output logic [3:0]  dcnt,
    output logic [31:0] dout,
    output logic        dout_vld,
    output logic        key_evt
);

    logic [CTRL_W-1:0] w_rise;
    logic              w_ent_evt;
    logic              w_del_evt;
    logic              w_dig_evt;
    logic [3:0]        w_digit;

    logic [31:0] r_din;
    logic [3:0]  r_dcnt;
    logic [31:0] r_dout;
    logic        r_dout_vld;
    logic        r_key_evt;

    input_debounce #(
        .WIDTH     (CTRL_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rstn (rstn),
        .raw  ({ent, del, hd}),
        .rise (w_rise)
    );

    // Commit beats delete beats digit; losers in the same cycle are dropped.
    assign w_ent_evt = w_rise[ENT_BIT];
    assign w_del_evt = ~w_ent_evt & w_rise[DEL_BIT];
    assign w_dig_evt = ~w_ent_evt & ~w_rise[DEL_BIT] & (|w_rise[15:0]);
    assign w_digit   = onehot_lsb_enc(w_rise[15:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_din      <= '0;
            r_dcnt     <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_key_evt  <= 1'b0;
        end else begin
            r_dout_vld <= w_ent_evt;
            r_key_evt  <= w_ent_evt | w_del_evt | w_dig_evt;
            if (w_ent_evt) begin
                r_dout <= r_din;
                r_din  <= '0;
                r_dcnt <= '0;
            end else if (w_del_evt) begin
                r_din <= {4'h0, r_din[31:4]};
                if (r_dcnt != 4'd0) r_dcnt <= r_dcnt - 4'd1;
            end else if (w_dig_evt) begin
                r_din <= {r_din[27:0], w_digit};
                if (r_dcnt != 4'(NIBBLES)) r_dcnt <= r_dcnt + 4'd1;
            end
        end
    end

    assign din      = r_din;
    assign dcnt     = r_dcnt;
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign key_evt  = r_key_evt;

endmodule
`default_nettype wire

// File: tb/tb_hex_key_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_key_entry
// Purpose  : Self-checking bench: queue-of-digits model, directed and random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_key_entry;

    logic        clk;
    logic        rstn;
    logic [15:0] hd1, hd4;
    logic        del1, ent1, del4, ent4;
    logic [31:0] din1, dout1, din4, dout4;
    logic [3:0]  dcnt1, dcnt4;
    logic        vld1, evt1, vld4, evt4;

    int total = 0;
    int bad   = 0;
    int evt1_cnt = 0, vld1_cnt = 0, evt4_cnt = 0;

    // Model state for the DB_CYCLES=1 instance: digits oldest first.
    logic [3:0]  q[$];
    logic [31:0] m_dout = '0;
    int          m_evt  = 0;
    int          m_vld  = 0;

    hex_key_entry #(.DB_CYCLES(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .hd(hd1), .del(del1), .ent(ent1),
        .din(din1), .dcnt(dcnt1), .dout(dout1), .dout_vld(vld1), .key_evt(evt1)
    );

    hex_key_entry #(.DB_CYCLES(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .hd(hd4), .del(del4), .ent(ent4),
        .din(din4), .dcnt(dcnt4), .dout(dout4), .dout_vld(vld4), .key_evt(evt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (evt1) evt1_cnt++;
        if (vld1) vld1_cnt++;
        if (evt4) evt4_cnt++;
    end

    function automatic logic [31:0] pack(input logic [3:0] dq[$]);
        logic [31:0] r;
        r = '0;
        foreach (dq[i]) r = (r << 4) | 32'(dq[i]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input logic [17:0] pat);
        int d;
        if (pat[17]) begin
            m_dout = pack(q);
            q.delete();
            m_vld++;
            m_evt++;
        end else if (pat[16]) begin
            if (q.size() > 0) void'(q.pop_back());
            m_evt++;
        end else if (pat[15:0] != 16'h0) begin
            d = 0;
            while (!pat[d]) d++;
            q.push_back(4'(d));
            if (q.size() > 8) void'(q.pop_front());
            m_evt++;
        end
    endtask

    task automatic check1(input string tag);
        chk({tag, "_din"},  din1, pack(q));
        chk({tag, "_dcnt"}, {28'h0, dcnt1}, 32'(q.size()));
        chk({tag, "_dout"}, dout1, m_dout);
        chk({tag, "_evt"},  32'(evt1_cnt), 32'(m_evt));
        chk({tag, "_vld"},  32'(vld1_cnt), 32'(m_vld));
    endtask

    // One-cycle press on the DB_CYCLES=1 instance, then settle.
    task automatic press1(input logic [17:0] pat);
        @(negedge clk);
        {ent1, del1, hd1} = pat;
        @(negedge clk);
        {ent1, del1, hd1} = '0;
        repeat (5) @(negedge clk);
        model_apply(pat);
    endtask

    task automatic press4(input int n);
        @(negedge clk);
        hd4 = 16'h0004;
        repeat (n) @(negedge clk);
        hd4 = 16'h0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [17:0] pat;
        int          op;
        rstn = 1'b0;
        hd1 = '0; del1 = 1'b0; ent1 = 1'b0;
        hd4 = '0; del4 = 1'b0; ent4 = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check1("reset");
        chk("reset_vld_now", {31'h0, vld1}, 32'h0);
        chk("reset_evt_now", {31'h0, evt1}, 32'h0);

        // Digits 1,2,3
        for (int i = 1; i <= 3; i++) press1(18'(1 << i));
        check1("d123");
        chk("d123_const", din1, 32'h0000_0123);

        // Nine digits then two deletes
        for (int i = 1; i <= 9; i++) press1(18'(1 << i));
        check1("d1to9");
        chk("d1to9_const", din1, 32'h2345_6789);
        press1(18'h10000);
        press1(18'h10000);
        check1("del2");
        chk("del2_const", din1, 32'h0023_4567);
        press1(18'h20000);
        check1("commit1");

        // A,B then commit with exact strobe timing
        press1(18'(1 << 10));
        press1(18'(1 << 11));
        @(negedge clk);
        ent1 = 1'b1;
        model_apply(18'h20000);
        @(negedge clk);
        ent1 = 1'b0;
        @(negedge clk);
        chk("ab_vld_k1", {31'h0, vld1}, 32'h0);
        @(negedge clk);
        chk("ab_vld_k2", {31'h0, vld1}, 32'h0);
        @(negedge clk);
        chk("ab_vld_k3", {31'h0, vld1}, 32'h1);
        chk("ab_dout", dout1, 32'h0000_00AB);
        @(negedge clk);
        chk("ab_vld_k4", {31'h0, vld1}, 32'h0);
        chk("ab_din0", din1, 32'h0);
        chk("ab_dcnt0", {28'h0, dcnt1}, 32'h0);
        repeat (4) @(negedge clk);
        check1("ab");

        // Simultaneous events
        press1({2'b01, 16'h0020});
        check1("del_beats_hd");
        press1({2'b00, 16'h0088});
        check1("lsb_wins");
        chk("lsb_wins_const", din1, 32'h3);

        // Reset mid-entry, hd[4] held through release
        for (int i = 0; i < 4; i++) press1(18'(1 << (i + 5)));
        check1("pre_rst");
        @(negedge clk);
        hd1 = 16'h0010;
        #2 rstn = 1'b0;
        #1;
        chk("rst_din",  din1, 32'h0);
        chk("rst_dcnt", {28'h0, dcnt1}, 32'h0);
        chk("rst_dout", dout1, 32'h0);
        q.delete();
        m_dout = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        hd1 = 16'h0;
        repeat (6) @(negedge clk);
        model_apply(18'h00010);
        check1("post_rst");

        // DB_CYCLES=4 glitch rejection and held switch
        press4(3);
        chk("db4_short_din", din4, 32'h0);
        chk("db4_short_evt", 32'(evt4_cnt), 32'h0);
        press4(4);
        chk("db4_ok_din", din4, 32'h2);
        chk("db4_ok_dcnt", {28'h0, dcnt4}, 32'h1);
        chk("db4_ok_evt", 32'(evt4_cnt), 32'h1);
        press4(100);
        chk("db4_hold_din", din4, 32'h22);
        chk("db4_hold_evt", 32'(evt4_cnt), 32'h2);
        chk("db4_vld", {31'h0, vld4}, 32'h0);

        // Random traffic on the DB_CYCLES=1 instance
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 9));
            pat = {2'b00, 16'($urandom)};
            if (pat[15:0] == 16'h0) pat[$urandom_range(0, 15)] = 1'b1;
            if (op >= 6 && op <= 7) begin
                pat[16] = 1'b1;
                if (op == 7) pat[15:0] = '0;
            end else if (op >= 8) begin
                pat[17] = 1'b1;
                pat[16] = 1'($urandom_range(0, 1));
            end
            press1(pat);
            check1($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
